sap1_controller_sequencer: RTL

Controller-sequencer for the SAP-1 datapath; it sits directly upstream of the 4-bit program counter and drives its increment enable. A six-state one-hot ring counter (T1–T6) steps through fetch and execute phases. Each T-state and the 4-bit opcode from the instruction register are decoded into the 12-bit control word that loads, enables and increments the datapath registers. An HLT instruction freezes the sequencer until reset.

---
 rtl/sap1_controller_sequencer.sv | 85 ++++++++
 1 files changed

// File: rtl/sap1_controller_sequencer.sv
// sap1_controller_sequencer: SAP-1 T1..T6 ring counter with HALT, decoding T-state and opcode into the control word.
// Define SAP1_CTRL_EARLY_FINISH_EN to skip trailing T-states that carry no control.
module sap1_controller_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] opcode,
  output logic       cp,
  output logic       ep,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb,
  output logic       lo,
  output logic       halted,
  output logic [5:0] tstate
);
  typedef enum logic [2:0] {T1, T2, T3, T4, T5, T6, HALT} state_t;
  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;
  state_t state_q, state_d;
  logic is_lda, is_arith, is_mem, is_out, is_hlt, is_nop, done;
  assign is_lda   = opcode == OP_LDA;
  assign is_arith = opcode == OP_ADD || opcode == OP_SUB;
  assign is_mem   = is_lda || is_arith;
  assign is_out   = opcode == OP_OUT;
  assign is_hlt   = opcode == OP_HLT;
  assign is_nop   = !is_mem && !is_out && !is_hlt;
`ifdef SAP1_CTRL_EARLY_FINISH_EN
  assign done = (state_q == T3 && is_nop) || (state_q == T4 && is_out) || (state_q == T5 && is_lda);
`else
  assign done = 1'b0;
`endif
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= T1;
    else       state_q <= state_d;
  end
  always_comb begin
    state_d = HALT;
    case (state_q)
      T1:      state_d = T2;
      T2:      state_d = T3;
      T3:      state_d = done ? T1 : T4;
      T4:      state_d = is_hlt ? HALT : (done ? T1 : T5);
      T5:      state_d = done ? T1 : T6;
      T6:      state_d = T1;
      default: state_d = HALT;
    endcase
  end
  // Moore decode; fetch states ignore opcode, HALT and unused codes drive nothing.
  always_comb begin
    {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo} = '0;
    case (state_q)
      T1: {ep, lm} = 2'b11;
      T2: cp = 1'b1;
      T3: {ce, li} = 2'b11;
      T4: begin
        ei = is_mem;
        lm = is_mem;
        ea = is_out;
        lo = is_out;
      end
      T5: begin
        ce = is_mem;
        la = is_lda;
        lb = is_arith;
      end
      T6: begin
        eu = is_arith;
        la = is_arith;
        su = opcode == OP_SUB;
      end
      default: ;
    endcase
  end
  assign halted = state_q == HALT;
  assign tstate = (state_q == HALT) ? 6'd0 : 6'd1 << state_q;
endmodule
